ddr3_ref_clk_training_ctrl: RTL and testbench
=============================================

// Module: ddr3_ref_clk_training_ctrl
// PURPOSE
//  Sequences the DDR3 CK0 reference-clock training IOD: reloads its RX delay line, steps taps up,
//  samples RX_DATA and finds the first tap where sampled CK level flips. Sits between the DDR PHY
//  training FSM (START/DONE/FAIL) and the IOD dynamic delay/eye-monitor controls, in FAB_CLK domain.
// PARAMETERS
//  MAX_TAPS      128  delay-line taps searched before FAIL (tap index 0..MAX_TAPS-1)
//  SETTLE_CYCLES 4    FAB_CLK cycles waited after LOAD or MOVE before sampling (>=1)
//  SAMPLE_CYCLES 8    RX_DATA words accumulated per tap (>=1)
//  TAP_W         $clog2(MAX_TAPS)  tap counter width (derived, do not override)
// PORTS
//  FAB_CLK                   in  1      fabric clock, same clock as the IOD RX_CLK
//  RESET                     in  1      synchronous, active-high reset
//  START                     in  1      one-cycle request; ignored while BUSY
//  BUSY                      out 1      training in progress
//  DONE                      out 1      level: edge found; held until next START/RESET
//  FAIL                      out 1      level: range exhausted or out-of-range; held until next START/RESET
//  EDGE_TAP                  out TAP_W  tap at which edge was found (valid with DONE)
//  REF_LEVEL                 out 1      stable CK level before the edge (valid with DONE)
//  RX_DATA                   in  8      IOD RX_DATA_0 word
//  DELAY_LINE_LOAD           out 1      one-cycle pulse, reloads tap to static value
//  DELAY_LINE_MOVE           out 1      one-cycle pulse, steps one tap
//  DELAY_LINE_DIRECTION      out 1      held 1 (increment) while BUSY, 0 otherwise
//  DELAY_LINE_OUT_OF_RANGE   in  1      IOD range flag
//  EYE_MONITOR_CLEAR_FLAGS   out 1      one-cycle pulse before each sample window (macro only)
//  EYE_MONITOR_EARLY/LATE    in  1 each IOD eye flags (macro only; unused otherwise)
// BEHAVIOUR
//  Reset: all outputs 0, EDGE_TAP=0, state IDLE. RESET mid-training aborts next edge; no reload
//   is issued until the next START.
//  States: IDLE -> LOAD -> WAIT -> CLEAR -> SAMPLE -> EVAL -> {MOVE -> WAIT | DONE | FAIL}.
//  IDLE/DONE/FAIL: START clears DONE/FAIL, tap:=0, has_ref:=0, BUSY:=1, go LOAD.
//  LOAD: DELAY_LINE_LOAD=1 for exactly one cycle; go WAIT.
//  WAIT: count SETTLE_CYCLES cycles, then CLEAR.
//  CLEAR: 1 cycle (clears accumulators; EYE_MONITOR_CLEAR_FLAGS pulse if macro); go SAMPLE.
//  SAMPLE: SAMPLE_CYCLES cycles; acc_or|=RX_DATA, acc_and&=RX_DATA (init 0x00/0xFF).
//  EVAL (1 cycle): class = LOW if acc_or==0, HIGH if acc_and==8'hFF, else MIXED.
//   - DELAY_LINE_OUT_OF_RANGE high at any point while BUSY -> FAIL (priority over all else).
//   - !has_ref & class!=MIXED: REF_LEVEL:=class, has_ref:=1, step.
//   - has_ref & class==~REF_LEVEL: EDGE_TAP:=tap, DONE:=1, BUSY:=0.
//   - otherwise (MIXED or same level): step.
//   - step: if tap==MAX_TAPS-1 -> FAIL (BUSY:=0); else MOVE.
//  MOVE: DELAY_LINE_MOVE=1 for one cycle, tap:=tap+1 (never wraps); go WAIT.
//  Latency per tap = 1+SETTLE_CYCLES+1+SAMPLE_CYCLES+1 cycles; DONE/FAIL rise the cycle after EVAL.
//  DONE and FAIL never both 1; LOAD and MOVE never both 1; START while BUSY has no effect.
// CONFIGURATION
//  `REFCLK_TRAIN_EYE_CHECK_EN defined: CLEAR pulses EYE_MONITOR_CLEAR_FLAGS; EARLY or LATE
//   latched during SAMPLE forces class=MIXED. Undefined: CLEAR_FLAGS tied 0, eye inputs ignored.
// STRUCTURE
//  Package ddr3_ref_clk_training_pkg: state enum, class enum {LOW,HIGH,MIXED}, default params.
//  Sub-module ddr3_ref_clk_sample_acc: clear/enable AND-OR accumulator + classifier, 8-bit word.
//  Top holds FSM, settle/sample counters, tap counter, result registers.
// TESTING
//  1 IOD model: CK level 0 for taps 0..36, 1 from 37 -> DONE=1, EDGE_TAP=37, REF_LEVEL=0,
//    exactly 1 LOAD and 37 MOVE pulses, BUSY low same cycle DONE high.
//  2 Level 1 taps 0..9, MIXED 10..11, 0 from 12 -> DONE, EDGE_TAP=12, REF_LEVEL=1.
//  3 Constant 0 all taps -> FAIL=1 after tap 127 EVAL, 127 MOVE pulses, DONE=0.
//  4 OUT_OF_RANGE asserted at tap 5 -> FAIL next cycle, no further MOVE; START reruns cleanly.
//  5 RESET asserted mid-SAMPLE at tap 20 -> all outputs 0 next edge; START while BUSY ignored.
//  6 With macro: EARLY pulsed at edge tap 37 only -> edge tap treated MIXED, EDGE_TAP=38;
//    CLEAR_FLAGS pulses once per tap; without macro CLEAR_FLAGS stays 0.

Source files
------------

// File: rtl/ddr3_ref_clk_training_pkg.sv
// Shared types and default parameters for the DDR3 CK0 reference-clock training controller.
// The optional eye-monitor qualification is enabled with `REFCLK_TRAIN_EYE_CHECK_EN.
package ddr3_ref_clk_training_pkg;

  localparam int DEF_MAX_TAPS      = 128;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_SAMPLE_CYCLES = 8;
  localparam int WORD_W            = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CLEAR,
    ST_SAMPLE,
    ST_EVAL,
    ST_MOVE,
    ST_DONE,
    ST_FAIL
  } train_state_e;

  typedef enum logic [1:0] {
    CLS_LOW,
    CLS_HIGH,
    CLS_MIXED
  } sample_class_e;

endpackage

// File: rtl/ddr3_ref_clk_sample_acc.sv
// AND/OR accumulator over RX_DATA words with a LOW/HIGH/MIXED classifier.
// An eye flag seen during the window forces the class to MIXED.
module ddr3_ref_clk_sample_acc
  import ddr3_ref_clk_training_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [WORD_W-1:0] data,
  input  logic              eye_flag,
  output sample_class_e     sample_class
);

  logic [WORD_W-1:0] acc_or;
  logic [WORD_W-1:0] acc_and;
  logic              eye_seen;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_or   <= '0;
      acc_and  <= '1;
      eye_seen <= 1'b0;
    end else if (enable) begin
      acc_or   <= acc_or | data;
      acc_and  <= acc_and & data;
      eye_seen <= eye_seen | eye_flag;
    end
  end

  always_comb begin
    sample_class = CLS_MIXED;
    if (eye_seen) begin
      sample_class = CLS_MIXED;
    end else if (acc_or == '0) begin
      sample_class = CLS_LOW;
    end else if (acc_and == '1) begin
      sample_class = CLS_HIGH;
    end
  end

endmodule

// File: rtl/ddr3_ref_clk_training_ctrl.sv
// Steps the CK0 RX delay line tap by tap and reports the first tap where the sampled CK level flips.
// Define `REFCLK_TRAIN_EYE_CHECK_EN to pulse EYE_MONITOR_CLEAR_FLAGS and reject taps flagged EARLY/LATE.
module ddr3_ref_clk_training_ctrl
  import ddr3_ref_clk_training_pkg::*;
#(
  parameter  int MAX_TAPS      = DEF_MAX_TAPS,
  parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter  int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  localparam int TAP_W         = $clog2(MAX_TAPS)
) (
  input  logic              FAB_CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [TAP_W-1:0]  EDGE_TAP,
  output logic              REF_LEVEL,
  input  logic [WORD_W-1:0] RX_DATA,
  output logic              DELAY_LINE_LOAD,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_DIRECTION,
  input  logic              DELAY_LINE_OUT_OF_RANGE,
  output logic              EYE_MONITOR_CLEAR_FLAGS,
  input  logic              EYE_MONITOR_EARLY,
  input  logic              EYE_MONITOR_LATE
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef REFCLK_TRAIN_EYE_CHECK_EN
  localparam bit EYE_EN = 1'b1;
  logic eye_flag;
  assign eye_flag = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
`else
  localparam bit EYE_EN = 1'b0;
  logic eye_flag;
  logic unused_eye;
  assign eye_flag   = 1'b0;
  assign unused_eye = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
`endif

  train_state_e  state;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] tap;
  logic          has_ref;
  sample_class_e sample_class;
  logic          class_level;
  logic          edge_seen;

  ddr3_ref_clk_sample_acc u_sample_acc (
    .clk          (FAB_CLK),
    .reset        (RESET),
    .clear        (state == ST_CLEAR),
    .enable       (state == ST_SAMPLE),
    .data         (RX_DATA),
    .eye_flag     (eye_flag),
    .sample_class (sample_class)
  );

  assign class_level          = (sample_class == CLS_HIGH);
  assign edge_seen            = has_ref && (sample_class != CLS_MIXED) && (class_level != REF_LEVEL);
  assign DELAY_LINE_DIRECTION = BUSY;

  // Out-of-range from the IOD aborts training from any busy state, ahead of the normal flow.
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state                   <= ST_IDLE;
      cnt                     <= '0;
      tap                     <= '0;
      has_ref                 <= 1'b0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      FAIL                    <= 1'b0;
      EDGE_TAP                <= '0;
      REF_LEVEL               <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
    end else begin
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      if (BUSY && DELAY_LINE_OUT_OF_RANGE) begin
        state <= ST_FAIL;
        FAIL  <= 1'b1;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (START) begin
              DONE            <= 1'b0;
              FAIL            <= 1'b0;
              tap             <= '0;
              has_ref         <= 1'b0;
              BUSY            <= 1'b1;
              DELAY_LINE_LOAD <= 1'b1;
              state           <= ST_LOAD;
            end
          end
          ST_LOAD, ST_MOVE: begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
              EYE_MONITOR_CLEAR_FLAGS <= EYE_EN;
              state                   <= ST_CLEAR;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_CLEAR: begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
              state <= ST_EVAL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_EVAL: begin
            if (edge_seen) begin
              EDGE_TAP <= tap;
              DONE     <= 1'b1;
              BUSY     <= 1'b0;
              state    <= ST_DONE;
            end else begin
              if (!has_ref && (sample_class != CLS_MIXED)) begin
                REF_LEVEL <= class_level;
                has_ref   <= 1'b1;
              end
              if (tap == TAP_W'(MAX_TAPS - 1)) begin
                FAIL  <= 1'b1;
                BUSY  <= 1'b0;
                state <= ST_FAIL;
              end else begin
                DELAY_LINE_MOVE <= 1'b1;
                tap             <= tap + TAP_W'(1);
                state           <= ST_MOVE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_ref_clk_training_ctrl.sv
// Directed bench for ddr3_ref_clk_training_ctrl with a simple IOD model driving RX_DATA by tap.
// Build with +define+REFCLK_TRAIN_EYE_CHECK_EN to check the eye-monitor variant.
module tb_ddr3_ref_clk_training_ctrl;

  logic       fab_clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       fail;
  logic [6:0] edge_tap;
  logic       ref_level;
  logic [7:0] rx_data;
  logic       dl_load;
  logic       dl_move;
  logic       dl_dir;
  logic       dl_oor;
  logic       eye_clear;
  logic       eye_early;
  logic       eye_late;

  int errors = 0;
  int checks = 0;

  int model_tap      = 0;
  int load_cnt       = 0;
  int move_cnt       = 0;
  int clear_cnt      = 0;
  int both_done_fail = 0;
  int both_load_move = 0;
  int mode           = 0;
  bit oor_en         = 1'b0;
  bit eye_en         = 1'b0;

`ifdef REFCLK_TRAIN_EYE_CHECK_EN
  localparam int EYE_EDGE   = 38;
  localparam int EYE_CLEARS = 39;
  localparam int EYE_CYC    = 585;
`else
  localparam int EYE_EDGE   = 37;
  localparam int EYE_CLEARS = 0;
  localparam int EYE_CYC    = 570;
`endif

  always #5 fab_clk = ~fab_clk;

  ddr3_ref_clk_training_ctrl dut (
    .FAB_CLK                 (fab_clk),
    .RESET                   (reset),
    .START                   (start),
    .BUSY                    (busy),
    .DONE                    (done),
    .FAIL                    (fail),
    .EDGE_TAP                (edge_tap),
    .REF_LEVEL               (ref_level),
    .RX_DATA                 (rx_data),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE (dl_oor),
    .EYE_MONITOR_CLEAR_FLAGS (eye_clear),
    .EYE_MONITOR_EARLY       (eye_early),
    .EYE_MONITOR_LATE        (eye_late)
  );

  // IOD model: the delay line position follows LOAD/MOVE pulses, and pulses are counted.
  always @(posedge fab_clk) begin
    if (dl_load) model_tap <= 0;
    else if (dl_move) model_tap <= model_tap + 1;
    if (dl_load) load_cnt <= load_cnt + 1;
    if (dl_move) move_cnt <= move_cnt + 1;
    if (eye_clear) clear_cnt <= clear_cnt + 1;
    if (done && fail) both_done_fail <= both_done_fail + 1;
    if (dl_load && dl_move) both_load_move <= both_load_move + 1;
  end

  always_comb begin
    rx_data = 8'h00;
    case (mode)
      0: if (model_tap >= 37) rx_data = 8'hFF;
      1: begin
        if (model_tap < 10) rx_data = 8'hFF;
        else if (model_tap < 12) rx_data = 8'h3C;
      end
      default: rx_data = 8'h00;
    endcase
  end

  assign dl_oor    = oor_en && (model_tap == 5);
  assign eye_early = eye_en && (model_tap == 37);
  assign eye_late  = 1'b0;

  task automatic run_and_wait(input int budget, output int cycles);
    start = 1'b1;
    @(negedge fab_clk);
    start  = 1'b0;
    cycles = 0;
    while (!(done || fail) && cycles < budget) begin
      @(negedge fab_clk);
      cycles++;
    end
    checks++;
    if (!(done || fail)) begin
      errors++;
      $display("[TB] FAIL run_timeout: no DONE/FAIL after %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge fab_clk);
    checks++;
    if ({busy, done, fail, edge_tap, ref_level, dl_load, dl_move, dl_dir, eye_clear} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {busy, done, fail, edge_tap, ref_level, dl_load, dl_move, dl_dir, eye_clear});
    end
    reset = 1'b0;
    repeat (5) @(negedge fab_clk);
    checks++;
    if (busy !== 1'b0 || load_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b loads=%0d expected busy=0 loads=0", busy, load_cnt);
    end
  endtask

  task automatic test_edge_low_to_high();
    int bl, bm, cyc;
    mode = 0;
    bl = load_cnt;
    bm = move_cnt;
    run_and_wait(3000, cyc);
    checks++;
    if (done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge1_flags: done=%b fail=%b busy=%b expected 1 0 0", done, fail, busy);
    end
    checks++;
    if (edge_tap !== 7'd37) begin
      errors++;
      $display("[TB] FAIL edge1_tap: got %0d expected 37", edge_tap);
    end
    checks++;
    if (ref_level !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge1_ref: got %b expected 0", ref_level);
    end
    checks++;
    if (load_cnt - bl !== 1 || move_cnt - bm !== 37) begin
      errors++;
      $display("[TB] FAIL edge1_pulses: loads=%0d moves=%0d expected 1 37", load_cnt - bl, move_cnt - bm);
    end
    checks++;
    if (cyc !== 570) begin
      errors++;
      $display("[TB] FAIL edge1_latency: got %0d cycles expected 570", cyc);
    end
  endtask

  task automatic test_mixed_region();
    int bm, cyc;
    mode = 1;
    bm = move_cnt;
    run_and_wait(3000, cyc);
    checks++;
    if (done !== 1'b1 || edge_tap !== 7'd12 || ref_level !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mixed_result: done=%b tap=%0d ref=%b expected 1 12 1", done, edge_tap, ref_level);
    end
    checks++;
    if (move_cnt - bm !== 12 || cyc !== 195) begin
      errors++;
      $display("[TB] FAIL mixed_timing: moves=%0d cycles=%0d expected 12 195", move_cnt - bm, cyc);
    end
  endtask

  task automatic test_no_edge();
    int bl, bm, cyc;
    mode = 2;
    bl = load_cnt;
    bm = move_cnt;
    run_and_wait(3000, cyc);
    checks++;
    if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noedge_flags: fail=%b done=%b busy=%b expected 1 0 0", fail, done, busy);
    end
    checks++;
    if (move_cnt - bm !== 127 || load_cnt - bl !== 1) begin
      errors++;
      $display("[TB] FAIL noedge_pulses: moves=%0d loads=%0d expected 127 1", move_cnt - bm, load_cnt - bl);
    end
    checks++;
    if (cyc !== 1920) begin
      errors++;
      $display("[TB] FAIL noedge_latency: got %0d cycles expected 1920", cyc);
    end
  endtask

  task automatic test_out_of_range();
    int bm, n, cyc;
    mode   = 2;
    oor_en = 1'b1;
    bm     = move_cnt;
    start  = 1'b1;
    @(negedge fab_clk);
    start = 1'b0;
    n = 0;
    while (move_cnt - bm < 5 && n < 500) begin
      @(negedge fab_clk);
      n++;
    end
    checks++;
    if (move_cnt - bm !== 5 || fail !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_reach: moves=%0d fail=%b expected 5 0", move_cnt - bm, fail);
    end
    @(negedge fab_clk);
    checks++;
    if (fail !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_abort: fail=%b busy=%b done=%b expected 1 0 0", fail, busy, done);
    end
    repeat (20) @(negedge fab_clk);
    checks++;
    if (move_cnt - bm !== 5) begin
      errors++;
      $display("[TB] FAIL oor_no_move: moves=%0d expected 5", move_cnt - bm);
    end
    oor_en = 1'b0;
    mode   = 0;
    run_and_wait(3000, cyc);
    checks++;
    if (done !== 1'b1 || fail !== 1'b0 || edge_tap !== 7'd37) begin
      errors++;
      $display("[TB] FAIL oor_rerun: done=%b fail=%b tap=%0d expected 1 0 37", done, fail, edge_tap);
    end
  endtask

  task automatic test_reset_mid_training();
    int bl, bm, n;
    mode  = 0;
    bl    = load_cnt;
    bm    = move_cnt;
    start = 1'b1;
    @(negedge fab_clk);
    start = 1'b0;
    n = 0;
    while (move_cnt - bm < 10 && n < 500) begin
      @(negedge fab_clk);
      n++;
    end
    start = 1'b1;
    @(negedge fab_clk);
    start = 1'b0;
    n = 0;
    while (move_cnt - bm < 20 && n < 500) begin
      @(negedge fab_clk);
      n++;
    end
    repeat (5) @(negedge fab_clk);
    checks++;
    if (busy !== 1'b1 || dl_dir !== 1'b1 || load_cnt - bl !== 1 || move_cnt - bm !== 20) begin
      errors++;
      $display("[TB] FAIL busy_restart: busy=%b dir=%b loads=%0d moves=%0d expected 1 1 1 20",
               busy, dl_dir, load_cnt - bl, move_cnt - bm);
    end
    reset = 1'b1;
    @(negedge fab_clk);
    checks++;
    if ({busy, done, fail, edge_tap, ref_level, dl_load, dl_move, dl_dir, eye_clear} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {busy, done, fail, edge_tap, ref_level, dl_load, dl_move, dl_dir, eye_clear});
    end
    reset = 1'b0;
    repeat (20) @(negedge fab_clk);
    checks++;
    if (busy !== 1'b0 || load_cnt - bl !== 1 || move_cnt - bm !== 20) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: busy=%b loads=%0d moves=%0d expected 0 1 20",
               busy, load_cnt - bl, move_cnt - bm);
    end
  endtask

  task automatic test_eye_monitor();
    int bc, cyc;
    mode   = 0;
    eye_en = 1'b1;
    bc     = clear_cnt;
    run_and_wait(3000, cyc);
    checks++;
    if (done !== 1'b1 || edge_tap !== 7'(EYE_EDGE) || cyc !== EYE_CYC) begin
      errors++;
      $display("[TB] FAIL eye_edge: done=%b tap=%0d cycles=%0d expected 1 %0d %0d",
               done, edge_tap, cyc, EYE_EDGE, EYE_CYC);
    end
    checks++;
    if (clear_cnt - bc !== EYE_CLEARS) begin
      errors++;
      $display("[TB] FAIL eye_clears: got %0d expected %0d", clear_cnt - bc, EYE_CLEARS);
    end
    eye_en = 1'b0;
  endtask

  task automatic test_exclusive_outputs();
    checks++;
    if (both_done_fail !== 0 || both_load_move !== 0) begin
      errors++;
      $display("[TB] FAIL exclusive: done&fail=%0d load&move=%0d expected 0 0", both_done_fail, both_load_move);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_edge_low_to_high();
    test_mixed_region();
    test_no_edge();
    test_out_of_range();
    test_reset_mid_training();
    test_eye_monitor();
    test_exclusive_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
